// File: rtl/uart_frame_scheduler.sv
// Serialises a captured debug snapshot onto a byte valid/ready stream:
// header, payload MSB-first, then an 8-bit additive checksum. One-deep pending slot.
module uart_frame_scheduler #(
   parameter int          FRAME_BYTES = 12,
   parameter logic [7:0]  HEADER      = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      snap_req,
   input  logic [8*FRAME_BYTES-1:0]  frame_in,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic                      pending,
   output logic [15:0]               frame_cnt,
   output logic [7:0]                drop_cnt
);

   localparam int         FW       = 8 * FRAME_BYTES;
   localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, SUM} state_t;

   state_t           state_q, state_d;
   logic [FW-1:0]    shift_q, pend_q;
   logic             pend_flag_q;
   logic [7:0]       csum_q, idx_q;
   logic [15:0]      frame_cnt_q;
   logic [7:0]       drop_cnt_q;

   logic             xfer, sum_xfer;
   logic             load_new, load_pend, capture, drop, shift_en, frame_done, pend_clr;
   logic [7:0]       cur_byte;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign xfer     = (state_q != IDLE) & tx_ready;
   assign sum_xfer = (state_q == SUM) & xfer;
   assign cur_byte = shift_q[FW-1 -: 8];

   always_comb begin
      state_d    = state_q;
      load_new   = 1'b0;
      load_pend  = 1'b0;
      capture    = 1'b0;
      drop       = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      pend_clr   = 1'b0;

      case (state_q)
         IDLE: begin
            if (snap_req) begin
               state_d  = HDR;
               load_new = 1'b1;
            end
         end
         HDR: begin
            if (xfer) state_d = DATA;
         end
         DATA: begin
            if (xfer) begin
               shift_en = 1'b1;
               if (idx_q == LAST_IDX) state_d = SUM;
            end
         end
         SUM: begin
            if (xfer) begin
               frame_done = 1'b1;
               if (pend_flag_q) begin
                  state_d   = HDR;
                  load_pend = 1'b1;
                  pend_clr  = 1'b1;
               end else if (snap_req) begin
                  state_d = HDR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A request at the closing SUM transfer either starts the next frame
      // directly or refills the slot the pending frame is vacating.
      if (snap_req && (state_q != IDLE)) begin
         if (sum_xfer) begin
            if (pend_flag_q) capture  = 1'b1;
            else             load_new = 1'b1;
         end else if (!pend_flag_q) begin
            capture = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         csum_q      <= 8'd0;
         idx_q       <= 8'd0;
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;

         if (load_new) begin
            shift_q <= frame_in;
            csum_q  <= 8'd0;
            idx_q   <= 8'd0;
         end else if (load_pend) begin
            shift_q <= pend_q;
            csum_q  <= 8'd0;
            idx_q   <= 8'd0;
         end else if (shift_en) begin
            shift_q <= shift_q << 8;
            csum_q  <= csum_q + cur_byte;
            idx_q   <= idx_q + 8'd1;
         end

         if (capture) begin
            pend_q      <= frame_in;
            pend_flag_q <= 1'b1;
         end else if (pend_clr) begin
            pend_flag_q <= 1'b0;
         end

         if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (drop)       drop_cnt_q  <= sat_inc8(drop_cnt_q);
      end
   end

   always_comb begin
      tx_data = 8'd0;
      case (state_q)
         HDR:     tx_data = HEADER;
         DATA:    tx_data = cur_byte;
         SUM:     tx_data = csum_q;
         default: tx_data = 8'd0;
      endcase
   end

   assign tx_valid  = (state_q != IDLE);
   assign busy      = (state_q != IDLE);
   assign pending   = pend_flag_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: table of frames, hand-written corner sequences,
// and random traffic, all checked against a byte-queue model of the frame stream.
module tb_uart_frame_scheduler;

   localparam int FB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          snap_req = 1'b0;
   logic [31:0]   frame_in = 32'd0;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          busy;
   logic          pending;
   logic [15:0]   frame_cnt;
   logic [7:0]    drop_cnt;

   always #5 clk = ~clk;

   uart_frame_scheduler #(.FRAME_BYTES(FB), .HEADER(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .frame_in(frame_in),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .pending(pending), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Model: bytes still to be sent for the frame in flight, plus the pending slot.
   logic [7:0]  mq[$];
   logic        m_pend = 1'b0;
   logic [31:0] m_pend_f = 32'd0;
   logic [15:0] m_fc = 16'd0;
   logic [7:0]  m_dc = 8'd0;
   logic [7:0]  last_sum = 8'd0;

   typedef struct {
      logic [31:0] f;
      int          mode;
      logic [7:0]  sum;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void push_frame(input logic [31:0] f);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'd0;
      mq.push_back(8'hA5);
      for (int i = FB - 1; i >= 0; i--) begin
         b = f[8*i +: 8];
         mq.push_back(b);
         s = s + b;
      end
      mq.push_back(s);
   endfunction

   task automatic step(input logic s, input logic [31:0] f, input logic r);
      logic inflight, x, last;
      @(negedge clk);
      inflight = (mq.size() > 0);
      chk("tx_valid", 32'(tx_valid), 32'(inflight));
      chk("busy", 32'(busy), 32'(inflight));
      if (inflight) chk("tx_data", 32'(tx_data), 32'(mq[0]));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
      snap_req = s;
      frame_in = f;
      tx_ready = r;
      x = inflight && r;
      last = 1'b0;
      if (x) begin
         if (mq.size() == 1) begin
            last = 1'b1;
            last_sum = tx_data;
            m_fc = m_fc + 16'd1;
         end
         void'(mq.pop_front());
      end
      if (!inflight) begin
         if (s) push_frame(f);
      end else if (last) begin
         if (m_pend) begin
            push_frame(m_pend_f);
            m_pend = s;
            if (s) m_pend_f = f;
         end else if (s) begin
            push_frame(f);
         end
      end else if (s) begin
         if (!m_pend) begin
            m_pend = 1'b1;
            m_pend_f = f;
         end else begin
            m_dc = (m_dc == 8'hFF) ? m_dc : m_dc + 8'd1;
         end
      end
   endtask

   function automatic logic rdy(input int mode, input int n);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (n % 2 == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic drain(input int mode, input int budget);
      int n;
      n = 0;
      while (mq.size() > 0 && n < budget) begin
         step(1'b0, 32'd0, rdy(mode, n));
         n++;
      end
      chk("drain_done", 32'(mq.size() > 0), 32'd0);
      step(1'b0, 32'd0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fc0;
      logic [7:0]  dc0;

      vt[0] = '{32'h11223344, 0, 8'hAA};
      vt[1] = '{32'h11223344, 1, 8'hAA};
      vt[2] = '{32'hFFFFFF03, 0, 8'h00};
      vt[3] = '{32'h01020304, 2, 8'h0A};
      vt[4] = '{32'h80FF7F01, 1, 8'hFF};

      // Reset state
      #12;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step(1'b0, 32'd0, 1'b1);

      // Table-driven single frames
      for (int i = 0; i < 5; i++) begin
         fc0 = m_fc;
         step(1'b1, vt[i].f, 1'b1);
         drain(vt[i].mode, 200);
         chk("vec_sum", 32'(last_sum), 32'(vt[i].sum));
         chk("vec_fcnt", 32'(frame_cnt), 32'(fc0 + 16'd1));
      end

      // Overrun: second request queued back-to-back, third dropped
      fc0 = m_fc;
      dc0 = drop_cnt;
      step(1'b1, 32'h01020304, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h0A0B0C0D, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b1, 32'hDEADBEEF, 1'b1);
      drain(0, 100);
      chk("ovr_drop", 32'(drop_cnt), 32'(dc0 + 8'd1));
      chk("ovr_fcnt", 32'(frame_cnt), 32'(fc0 + 16'd2));

      // Request coincident with the SUM transfer, nothing pending
      dc0 = drop_cnt;
      step(1'b1, 32'h11223344, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 1'b1);
      step(1'b1, 32'hCAFEF00D, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      chk("simul_hdr", 32'(tx_data), 32'hA5);
      chk("simul_valid", 32'(tx_valid), 32'd1);
      chk("simul_drop", 32'(drop_cnt), 32'(dc0));
      drain(0, 100);

      // Asynchronous reset in DATA byte 2 with a frame pending
      step(1'b1, 32'h01020304, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b1, 32'h0A0B0C0D, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 1'b0);
      chk("pre_rst_pending", 32'(pending), 32'd1);
      chk("pre_rst_byte2", 32'(tx_data), 32'h03);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx_valid", 32'(tx_valid), 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
      mq.delete();
      m_pend = 1'b0;
      m_fc = 16'd0;
      m_dc = 8'd0;
      snap_req = 1'b0;
      step(1'b0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) step(1'b0, 32'd0, 1'b1);

      // Drop counter saturation with the sink stalled
      step(1'b1, 32'h12345678, 1'b0);
      step(1'b1, 32'h9ABCDEF0, 1'b0);
      for (int k = 0; k < 300; k++) step(1'b1, $urandom, 1'b0);
      step(1'b0, 32'd0, 1'b0);
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      drain(0, 100);

      // Random traffic
      for (int k = 0; k < 600; k++)
         step(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) != 0));
      drain(2, 400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
